// File: rtl/alu_seq_core.sv
// Sequential ALU core: a debounced action button loads A then B, single-cycle ops
// finish in one EXEC cycle, MUL/DIV iterate one bit per cycle for WIDTH cycles.
module alu_seq_core #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               do_action,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   out_a,
  output logic [WIDTH-1:0]   out_b,
  output logic [2*WIDTH-1:0] out_y,
  output logic [4:0]         flags,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               done
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IT_W = $clog2(WIDTH);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IT_W-1:0]  IT_LAST   = IT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_LOAD_B,
    S_EXEC,
    S_ITER,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [2*WIDTH-1:0] y;
    logic [4:0]         f;
  } result_t;

  // Flag vector order: {err, negative, overflow, carry, zero}
  function automatic logic [4:0] pack_flags(input logic [2*WIDTH-1:0] y,
                                            input logic e, input logic n,
                                            input logic v, input logic c);
    return {e, n, v, c, (y == '0)};
  endfunction

  function automatic result_t single_op(input logic [3:0]       opc,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    logic [WIDTH:0]          wide;
    logic signed [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0]        r;
    logic                    c, v, e;
    result_t                 res;
    wide = '0;
    r    = '0;
    c    = 1'b0;
    v    = 1'b0;
    e    = 1'b0;
    sa   = a;
    sb   = b;
    case (opc)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r    = wide[WIDTH-1:0];
        c    = wide[WIDTH];
        sr   = r;
        v    = (sa[WIDTH-1] == sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
      end
      OP_SUB: begin
        r  = a - b;
        c  = (a < b);
        sr = r;
        v  = (sa[WIDTH-1] != sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: r = (b >= SHIFT_LIM) ? '0 : (a << b);
      OP_SHR: r = (b >= SHIFT_LIM) ? '0 : (a >> b);
      default: e = 1'b1;
    endcase
    res.y = {{WIDTH{1'b0}}, r};
    res.f = pack_flags(res.y, e, r[WIDTH-1], v, c);
    return res;
  endfunction

  state_t              state, state_next;
  logic                sync_p0, sync_p1;
  logic [DB_W-1:0]     db_cnt;
  logic                db_level, db_level_p2;
  logic                press;
  logic [3:0]          op_q;
  logic [IT_W-1:0]     iter_cnt;
  logic [2*WIDTH-1:0]  acc, mcand;
  logic [WIDTH-1:0]    mplier, rem, quot;
  logic [2*WIDTH-1:0]  mul_sum;
  logic [WIDTH:0]      div_shift, div_trial;
  logic                div_ok;
  logic [WIDTH-1:0]    rem_next, quot_next;
  logic [2*WIDTH-1:0]  iter_y;
  logic [4:0]          iter_f;
  logic                iterative, iter_last;
  result_t             exec_res;

  // Input conditioning: 2-flop synchroniser, stability counter, registered rising edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0     <= 1'b0;
      sync_p1     <= 1'b0;
      db_cnt      <= '0;
      db_level    <= 1'b0;
      db_level_p2 <= 1'b0;
      press       <= 1'b0;
    end else begin
      sync_p0 <= do_action;
      sync_p1 <= sync_p0;
      if (sync_p1 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      db_level_p2 <= db_level;
      press       <= db_level & ~db_level_p2;
    end
  end

  assign iterative = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign iter_last = (iter_cnt == IT_LAST);
  assign exec_res  = single_op(op_q, out_a, out_b);

  always_comb begin
    mul_sum   = acc + (mplier[0] ? mcand : '0);
    div_shift = {rem, quot[WIDTH-1]};
    div_trial = div_shift - {1'b0, out_b};
    div_ok    = ~div_trial[WIDTH];
    rem_next  = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
    quot_next = {quot[WIDTH-2:0], div_ok};
    if (op_q == OP_MUL) begin
      iter_y = mul_sum;
      iter_f = pack_flags(mul_sum, 1'b0, mul_sum[2*WIDTH-1], 1'b0, 1'b0);
    end else begin
      iter_y = {rem_next, quot_next};
      iter_f = pack_flags({rem_next, quot_next}, (out_b == '0), 1'b0, 1'b0, 1'b0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_LOAD_A;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    phase      = 2'd0;
    busy       = 1'b0;
    case (state)
      S_LOAD_A: if (press) state_next = S_LOAD_B;
      S_LOAD_B: begin
        phase = 2'd1;
        if (press) state_next = S_EXEC;
      end
      S_EXEC: begin
        phase      = 2'd2;
        busy       = 1'b1;
        state_next = iterative ? S_ITER : S_DONE;
      end
      S_ITER: begin
        phase = 2'd2;
        busy  = 1'b1;
        if (iter_last) state_next = S_DONE;
      end
      S_DONE: begin
        phase = 2'd3;
        if (press) state_next = S_LOAD_B;
      end
      default: state_next = S_LOAD_A;
    endcase
  end

  // Operand capture, iteration datapath and result/flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_a    <= '0;
      out_b    <= '0;
      out_y    <= '0;
      flags    <= '0;
      done     <= 1'b0;
      op_q     <= '0;
      iter_cnt <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quot     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_LOAD_A, S_DONE: begin
          if (press) out_a <= data_in;
        end
        S_LOAD_B: begin
          if (press) begin
            out_b <= data_in;
            op_q  <= op;
          end
        end
        S_EXEC: begin
          iter_cnt <= '0;
          if (op_q == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, out_a};
            mplier <= out_b;
          end else if (op_q == OP_DIV) begin
            rem  <= '0;
            quot <= out_a;
          end else begin
            out_y <= exec_res.y;
            flags <= exec_res.f;
            done  <= 1'b1;
          end
        end
        S_ITER: begin
          iter_cnt <= iter_cnt + IT_W'(1);
          acc      <= mul_sum;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          rem      <= rem_next;
          quot     <= quot_next;
          if (iter_last) begin
            out_y <= iter_y;
            flags <= iter_f;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core (WIDTH=8, DEBOUNCE_CYCLES=4): stimulus pushes
// expected results, a negedge monitor pops and compares on every done pulse.
module tb_alu_seq_core;

  logic        clock;
  logic        reset;
  logic        do_action;
  logic [3:0]  op;
  logic [7:0]  data_in;
  logic [7:0]  out_a;
  logic [7:0]  out_b;
  logic [15:0] out_y;
  logic [4:0]  flags;
  logic [1:0]  phase;
  logic        busy;
  logic        done;

  typedef struct {
    logic [15:0] y;
    logic [4:0]  f;
    logic [7:0]  a;
    logic [7:0]  b;
    int          busy_n;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  alu_seq_core #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .do_action (do_action),
    .op        (op),
    .data_in   (data_in),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_y     (out_y),
    .flags     (flags),
    .phase     (phase),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every completed result against the head of the scoreboard
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        exp_t e;
        check("done_single_pulse", {31'd0, prev_done}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("out_y", {16'd0, out_y}, {16'd0, e.y});
          check("flags", {27'd0, flags}, {27'd0, e.f});
          check("busy_cycles", busy_cnt, e.busy_n);
          check("out_a", {24'd0, out_a}, {24'd0, e.a});
          check("out_b", {24'd0, out_b}, {24'd0, e.b});
        end
        busy_cnt = 0;
      end
      prev_done = done;
    end
  end

  task automatic push_exp(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] y, input logic [4:0] f, input int bn);
    exp_t e;
    e.y = y; e.f = f; e.a = a; e.b = b; e.busy_n = bn;
    sb_q.push_back(e);
  endtask

  // Clean press with release bounce; inputs scrambled afterwards
  task automatic press(input logic [7:0] d, input logic [3:0] o);
    @(negedge clock);
    data_in   = d;
    op        = o;
    do_action = 1'b1;
    repeat (10) @(negedge clock);
    do_action = 1'b0;
    data_in   = ~d;
    op        = ~o;
    @(negedge clock);
    do_action = 1'b1;
    @(negedge clock);
    do_action = 1'b0;
    @(negedge clock);
    do_action = 1'b1;
    repeat (2) @(negedge clock);
    do_action = 1'b0;
    repeat (12) @(negedge clock);
  endtask

  task automatic wait_phase(input logic [1:0] p, input string name);
    int i;
    i = 0;
    while (phase !== p && i < 60) begin
      @(negedge clock);
      i++;
    end
    check(name, {30'd0, phase}, {30'd0, p});
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] o,
                        input logic [15:0] y, input logic [4:0] f, input int bn);
    push_exp(a, b, y, f, bn);
    press(a, 4'd0);
    press(b, o);
    wait_phase(2'd3, "phase_done");
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    do_action = 1'b0;
    op        = 4'd0;
    data_in   = 8'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_out_a", {24'd0, out_a}, 32'd0);
    check("rst_out_b", {24'd0, out_b}, 32'd0);
    check("rst_out_y", {16'd0, out_y}, 32'd0);
    check("rst_flags", {27'd0, flags}, 32'd0);
    check("rst_phase", {30'd0, phase}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // Two-cycle glitches must not register as presses
    @(negedge clock);
    data_in   = 8'hAA;
    do_action = 1'b1;
    repeat (2) @(negedge clock);
    do_action = 1'b0;
    repeat (6) @(negedge clock);
    do_action = 1'b1;
    repeat (2) @(negedge clock);
    do_action = 1'b0;
    repeat (12) @(negedge clock);
    check("glitch_phase", {30'd0, phase}, 32'd0);
    check("glitch_out_a", {24'd0, out_a}, 32'd0);

    // Long press with bouncy release: exactly one press
    data_in   = 8'd200;
    do_action = 1'b1;
    repeat (20) @(negedge clock);
    do_action = 1'b0;
    @(negedge clock);
    do_action = 1'b1;
    @(negedge clock);
    do_action = 1'b0;
    @(negedge clock);
    do_action = 1'b1;
    @(negedge clock);
    do_action = 1'b0;
    repeat (15) @(negedge clock);
    check("long_press_phase", {30'd0, phase}, 32'd1);
    check("long_press_out_a", {24'd0, out_a}, 32'd200);

    push_exp(8'd200, 8'd100, 16'h002C, 5'b00010, 1);
    press(8'd100, 4'd0);
    wait_phase(2'd3, "add_phase_done");

    run_op(8'd5,   8'd7, 4'd1, 16'h00FE, 5'b01010, 1);
    run_op(8'h80,  8'd1, 4'd1, 16'h007F, 5'b00100, 1);
    run_op(8'h7F,  8'd1, 4'd0, 16'h0080, 5'b01100, 1);

    // MUL with a second press landing mid-ITER that must be ignored
    push_exp(8'hFF, 8'hFF, 16'hFE01, 5'b01000, 9);
    press(8'hFF, 4'd0);
    @(negedge clock);
    data_in   = 8'hFF;
    op        = 4'd8;
    do_action = 1'b1;
    repeat (4) @(negedge clock);
    do_action = 1'b0;
    repeat (4) @(negedge clock);
    data_in   = 8'h11;
    op        = 4'd0;
    do_action = 1'b1;
    repeat (12) @(negedge clock);
    do_action = 1'b0;
    repeat (12) @(negedge clock);
    check("mul_ignored_press_phase", {30'd0, phase}, 32'd3);
    check("mul_ignored_press_out_a", {24'd0, out_a}, 32'hFF);

    run_op(8'd100, 8'd7,  4'd9,  16'h020E, 5'b00000, 9);
    run_op(8'd100, 8'd0,  4'd9,  16'h64FF, 5'b10000, 9);
    run_op(8'd3,   8'd4,  4'd12, 16'h0000, 5'b10001, 1);
    run_op(8'h81,  8'd1,  4'd6,  16'h0002, 5'b00000, 1);
    run_op(8'hF0,  8'd8,  4'd7,  16'h0000, 5'b00001, 1);
    run_op(8'hF0,  8'h3C, 4'd4,  16'h00CC, 5'b01000, 1);
    run_op(8'hF0,  8'h0F, 4'd2,  16'h0000, 5'b00001, 1);
    run_op(8'h0F,  8'h00, 4'd5,  16'h00F0, 5'b01000, 1);

    // Reset asserted three iterations into a MUL
    press(8'h0F, 4'd0);
    @(negedge clock);
    data_in   = 8'hF0;
    op        = 4'd8;
    do_action = 1'b1;
    for (int i = 0; i < 30 && !busy; i++) @(negedge clock);
    check("rst_iter_busy_seen", {31'd0, busy}, 32'd1);
    do_action = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_iter_mid_phase", {30'd0, phase}, 32'd2);
    reset = 1'b1;
    #1;
    check("rst_iter_out_a", {24'd0, out_a}, 32'd0);
    check("rst_iter_out_b", {24'd0, out_b}, 32'd0);
    check("rst_iter_out_y", {16'd0, out_y}, 32'd0);
    check("rst_iter_flags", {27'd0, flags}, 32'd0);
    check("rst_iter_phase", {30'd0, phase}, 32'd0);
    check("rst_iter_busy", {31'd0, busy}, 32'd0);
    check("rst_iter_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    press(8'h33, 4'd0);
    check("post_rst_phase", {30'd0, phase}, 32'd1);
    check("post_rst_out_a", {24'd0, out_a}, 32'h33);
    push_exp(8'h33, 8'h11, 16'h0044, 5'b00000, 1);
    press(8'h11, 4'd0);
    wait_phase(2'd3, "post_rst_add_done");

    repeat (5) @(negedge clock);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
